window_gen_5x5: RTL and testbench

- Streaming 5x5 neighbourhood generator for the SNN front end.
- Accepts one raster-order pixel per valid cycle and keeps four row-delay lines plus a 5-column shift window.
- Presents all 25 window pixels in parallel with a valid strobe, to feed window_freq's val1..val25 inputs.
- Emits only fully-interior windows, with no border padding.

---
 rtl/window_gen_5x5_pkg.sv | 20 ++
 rtl/window_gen_5x5_line_delay.sv | 34 +++
 rtl/window_gen_5x5.sv | 124 ++++++++++++
 tb/tb_window_gen_5x5.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/window_gen_5x5_pkg.sv
// ==========================================================================
// window_gen_5x5_pkg : shared constants and val-k slice helper | Rev 1.0
// ==========================================================================
`default_nettype none

package window_gen_5x5_pkg;

   localparam int WIN_DIM   = 5;
   localparam int WIN_N     = WIN_DIM * WIN_DIM;
   localparam int PIX_W_DEF = 8;
   localparam int LINES     = WIN_DIM - 1;

   // Bit offset of window value k (1-based) inside a flattened window bus
   function automatic int val_lsb(input int k, input int pix_w);
      return (k - 1) * pix_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/window_gen_5x5_line_delay.sv
// ==========================================================================
// line_delay : one image row of pixel delay, advanced on en | Rev 1.0
// ==========================================================================
`default_nettype none

module line_delay
   import window_gen_5x5_pkg::*;
#(
   parameter int DEPTH = 28,
   parameter int PIX_W = PIX_W_DEF
)(
   input  logic             clk,
   input  logic             en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   logic [PIX_W-1:0] r_mem [DEPTH];

   // Contents are never cleared; window validity comes from the counters
   always_ff @(posedge clk) begin
      if (en) begin
         r_mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            r_mem[i] <= r_mem[i-1];
         end
      end
   end

   assign dout = r_mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/window_gen_5x5.sv
// ==========================================================================
// window_gen_5x5 : streaming 5x5 interior-window generator | Rev 1.0
// ==========================================================================
`default_nettype none

module window_gen_5x5
   import window_gen_5x5_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int PIX_W = PIX_W_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIX_W-1:0]       pix_in,
   input  logic                   pix_valid,
   input  logic                   frame_start,
   output logic [WIN_N*PIX_W-1:0] win_flat,
   output logic                   win_valid,
   output logic                   frame_done
);

   localparam int               CNT_W      = 8;
   localparam logic [CNT_W-1:0] C_LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] C_LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] C_EDGE     = CNT_W'(WIN_DIM - 1);

   logic [CNT_W-1:0]       r_col, r_row;
   logic [CNT_W-1:0]       w_col, w_row;
   logic                   w_last, w_win;
   logic [PIX_W-1:0]       w_line_out [LINES];
   logic [PIX_W-1:0]       w_tap      [WIN_DIM];
   logic [PIX_W-1:0]       r_hist     [WIN_DIM][WIN_DIM-1];
   logic [PIX_W-1:0]       w_win_px   [WIN_DIM][WIN_DIM];
   logic [WIN_N*PIX_W-1:0] w_flat;

   // Position of the pixel presented this cycle; frame_start forces (0,0)
   always_comb begin
      w_col  = frame_start ? '0 : r_col;
      w_row  = frame_start ? '0 : r_row;
      w_last = (w_col == C_LAST_COL) && (w_row == C_LAST_ROW);
      w_win  = (w_col >= C_EDGE) && (w_row >= C_EDGE);
   end

   generate
      for (genvar i = 0; i < LINES; i++) begin : g_line
         logic [PIX_W-1:0] w_din;
         if (i == 0) begin : g_head
            assign w_din = pix_in;
         end else begin : g_chain
            assign w_din = w_line_out[i-1];
         end
         line_delay #(
            .DEPTH (IMG_W),
            .PIX_W (PIX_W)
         ) u_line (
            .clk  (clk),
            .en   (pix_valid),
            .din  (w_din),
            .dout (w_line_out[i])
         );
         assign w_tap[WIN_DIM-2-i] = w_line_out[i];
      end
   endgenerate

   assign w_tap[WIN_DIM-1] = pix_in;

   // Window including the pixel just accepted: four held columns plus the taps
   generate
      for (genvar r = 0; r < WIN_DIM; r++) begin : g_wr
         for (genvar c = 0; c < WIN_DIM; c++) begin : g_wc
            if (c < WIN_DIM - 1) begin : g_hist
               assign w_win_px[r][c] = r_hist[r][c];
            end else begin : g_new
               assign w_win_px[r][c] = w_tap[r];
            end
            assign w_flat[val_lsb(r*WIN_DIM + c + 1, PIX_W) +: PIX_W] = w_win_px[r][c];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (pix_valid) begin
         for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM - 1; c++) begin
               r_hist[r][c] <= w_win_px[r][c+1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_col      <= '0;
         r_row      <= '0;
         win_flat   <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (pix_valid) begin
            if (w_last) begin
               r_col      <= '0;
               r_row      <= '0;
               frame_done <= 1'b1;
            end else if (w_col == C_LAST_COL) begin
               r_col <= '0;
               r_row <= w_row + 1'b1;
            end else begin
               r_col <= w_col + 1'b1;
               r_row <= w_row;
            end
            if (w_win) begin
               win_flat  <= w_flat;
               win_valid <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_window_gen_5x5.sv
// ==========================================================================
// tb_window_gen_5x5 : randomized bench with image-array reference model | Rev 1.0
// ==========================================================================
`default_nettype none

module tb_window_gen_5x5;
   import window_gen_5x5_pkg::*;

   localparam int W  = 28;
   localparam int H  = 28;
   localparam int P  = 8;
   localparam int NB = WIN_N * P;

   localparam int PAT_RAMP  = 0;
   localparam int PAT_CONST = 1;
   localparam int PAT_RAND  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [P-1:0]  pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          frame_start = 1'b0;
   logic [NB-1:0] win_flat;
   logic          win_valid;
   logic          frame_done;

   always #5 clk = ~clk;

   window_gen_5x5 #(
      .IMG_W (W),
      .IMG_H (H),
      .PIX_W (P)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_in      (pix_in),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .win_flat    (win_flat),
      .win_valid   (win_valid),
      .frame_done  (frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: pixels stored by image coordinate, windows read back from the image
   logic [P-1:0]  img [H][W];
   int            m_idx = 0;
   logic          e_valid = 1'b0;
   logic          e_done = 1'b0;
   logic [NB-1:0] e_flat = '0;

   int            dut_wins, dut_dones;
   bit            have_first, const_mode;
   logic [NB-1:0] first_win;

   task automatic step(input bit v, input logic [P-1:0] px, input bit fs, input bit rs);
      int r, c;
      rst = rs; pix_valid = v; pix_in = px; frame_start = fs;
      if (!rs) begin
         m_idx = 0; e_valid = 1'b0; e_done = 1'b0; e_flat = '0;
      end else if (v) begin
         if (fs) m_idx = 0;
         r = m_idx / W;
         c = m_idx % W;
         img[r][c] = px;
         e_valid = (r >= 4) && (c >= 4);
         e_done  = (m_idx == W*H - 1);
         if (e_valid) begin
            for (int wr = 0; wr < 5; wr++)
               for (int wc = 0; wc < 5; wc++)
                  e_flat[(wr*5 + wc)*P +: P] = img[r-4+wr][c-4+wc];
         end
         m_idx = e_done ? 0 : m_idx + 1;
      end else begin
         e_valid = 1'b0; e_done = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("win_valid",  NB'(win_valid),  NB'(e_valid));
      check("frame_done", NB'(frame_done), NB'(e_done));
      check("win_flat",   win_flat,        e_flat);
      if (win_valid) begin
         dut_wins++;
         if (!have_first) begin
            have_first = 1'b1;
            first_win  = win_flat;
         end
         if (const_mode)
            for (int k = 1; k <= WIN_N; k++)
               check("const_val", NB'(win_flat[val_lsb(k, P) +: P]), NB'(8'hFF));
      end
      if (frame_done) dut_dones++;
   endtask

   task automatic send(input int n, input int pat, input bit fs0, input int gap_max);
      logic [P-1:0] px;
      for (int i = 0; i < n; i++) begin
         if (gap_max > 0)
            repeat ($urandom_range(gap_max)) step(1'b0, P'($urandom), 1'($urandom), 1'b1);
         case (pat)
            PAT_RAMP:  px = P'(i);
            PAT_CONST: px = 8'hFF;
            default:   px = P'($urandom);
         endcase
         step(1'b1, px, fs0 && (i == 0), 1'b1);
      end
   endtask

   task automatic clear_stats();
      dut_wins = 0; dut_dones = 0; have_first = 1'b0; first_win = '0;
   endtask

   task automatic check_first_ramp(input string tag);
      logic [NB-1:0] w;
      w = first_win;
      check({tag, "_val1"},  NB'(w[val_lsb(1, P)  +: P]), NB'(0));
      check({tag, "_val5"},  NB'(w[val_lsb(5, P)  +: P]), NB'(4));
      check({tag, "_val13"}, NB'(w[val_lsb(13, P) +: P]), NB'(58));
      check({tag, "_val21"}, NB'(w[val_lsb(21, P) +: P]), NB'(112));
      check({tag, "_val25"}, NB'(w[val_lsb(25, P) +: P]), NB'(116));
   endtask

   initial begin
      clear_stats();
      const_mode = 1'b0;
      @(negedge clk);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);

      // Ramp frame, no gaps
      clear_stats();
      send(W*H, PAT_RAMP, 1'b0, 0);
      step(1'b0, '0, 1'b0, 1'b1);
      check("ramp_wins", NB'(dut_wins), NB'(576));
      check("ramp_done", NB'(dut_dones), NB'(1));
      check_first_ramp("ramp_first");

      // Ramp frame with random gaps and stray frame_start during gaps
      clear_stats();
      send(W*H, PAT_RAMP, 1'b1, 5);
      check("gap_wins", NB'(dut_wins), NB'(576));
      check("gap_done", NB'(dut_dones), NB'(1));
      check_first_ramp("gap_first");

      // Two back-to-back ramp frames
      clear_stats();
      send(W*H, PAT_RAMP, 1'b0, 0);
      send(W*H, PAT_RAMP, 1'b0, 0);
      check("b2b_wins", NB'(dut_wins), NB'(1152));
      check("b2b_done", NB'(dut_dones), NB'(2));

      // Frame aborted at pixel 300 by frame_start
      clear_stats();
      send(300, PAT_RAMP, 1'b0, 0);
      have_first = 1'b0;
      send(W*H, PAT_RAMP, 1'b1, 0);
      check("abort_wins", NB'(dut_wins), NB'(160 + 576));
      check("abort_done", NB'(dut_dones), NB'(1));
      check_first_ramp("abort_first");

      // Reset mid-frame
      clear_stats();
      send(200, PAT_RAND, 1'b0, 2);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      check("rst_valid", NB'(win_valid), NB'(0));
      check("rst_flat",  win_flat, '0);
      have_first = 1'b0;
      send(W*H, PAT_RAMP, 1'b0, 0);
      check("rst_wins", NB'(dut_wins), NB'(72 + 576));
      check("rst_done", NB'(dut_dones), NB'(1));
      check_first_ramp("rst_first");

      // Random frame then constant 0xFF frame
      clear_stats();
      send(W*H, PAT_RAND, 1'b1, 3);
      const_mode = 1'b1;
      send(W*H, PAT_CONST, 1'b1, 1);
      const_mode = 1'b0;
      check("mix_wins", NB'(dut_wins), NB'(1152));
      repeat (3) step(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
